// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline-stage types and default payload field widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int c_PC_W      = 32;
    localparam int c_INSTR_W   = 32;
    localparam int c_ALUOP_W   = 11;
    localparam int c_NB_W      = 3;
    localparam int c_BHT_W     = 2;
    localparam int c_PATTERN_W = 8;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline register with a one-entry skid buffer,
//               registered in_ready and a flush (squash) input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_e      r_state_q, w_state_d;
    logic [DATA_W-1:0] r_main_q,  w_main_d;
    logic [DATA_W-1:0] r_skid_q,  w_skid_d;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_skid_load;

    assign out_valid  = (r_state_q != EMPTY);
    assign in_ready   = (r_state_q != FULL);
    assign out_data   = r_main_q;
    assign occupancy  = r_state_q;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_d   = r_state_q;
        w_main_d    = r_main_q;
        w_skid_d    = r_skid_q;
        w_skid_load = 1'b0;
        if (flush) begin
            // A same-cycle out_fire already completed; a same-cycle in_fire is dropped
            w_state_d = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                w_main_d = '0;
                w_skid_d = '0;
            end
        end else begin
            unique case (r_state_q)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_d = BUSY;
                        w_main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_d = in_data;
                    end else if (w_in_fire) begin
                        w_state_d   = FULL;
                        w_skid_d    = in_data;
                        w_skid_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_d = BUSY;
                        w_main_d  = r_skid_q;
                    end
                end
                default: w_state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= EMPTY;
            r_main_q  <= '0;
            r_skid_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_main_q  <= w_main_d;
            r_skid_q  <= w_skid_d;
        end
    end

    a_skid_only_from_busy : assert property (
        @(posedge clk) disable iff (rst) w_skid_load |-> (r_state_q == BUSY));

    a_out_data_stable : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

    a_occupancy_legal : assert property (
        @(posedge clk) disable iff (rst) occupancy != 2'd3);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench; two stages (clear / hold on flush) share
//               stimulus and are compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        in_ready_c, out_valid_c, in_ready_h, out_valid_h;
    logic [31:0] out_data_c, out_data_h;
    logic [1:0]  occ_c, occ_h;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mq[$];
    logic [31:0] last_c;
    logic [31:0] last_h;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CLEAR_ON_FLUSH(1)) u_dut_clear (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .occupancy(occ_c)
    );

    pipe_stage_skid #(.DATA_W(32), .CLEAR_ON_FLUSH(0)) u_dut_hold (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
        .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
        .occupancy(occ_h)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: FIFO of held entries (max 2); front is what the stage presents.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic orr, input logic [31:0] d);
        logic ifire, ofire;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = orr;
        in_data   = d;
        ifire = iv && (mq.size() < 2);
        ofire = orr && (mq.size() > 0);
        if (r) begin
            mq.delete();
            last_c = '0;
            last_h = '0;
        end else if (f) begin
            mq.delete();
            last_c = '0;
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(d);
            if (mq.size() > 0) begin
                last_c = mq[0];
                last_h = mq[0];
            end
        end
        @(posedge clk);
        #1;
        check_eq("occupancy_c", {30'd0, occ_c},       mq.size());
        check_eq("occupancy_h", {30'd0, occ_h},       mq.size());
        check_eq("out_valid_c", {31'd0, out_valid_c}, {31'd0, mq.size() > 0});
        check_eq("out_valid_h", {31'd0, out_valid_h}, {31'd0, mq.size() > 0});
        check_eq("in_ready_c",  {31'd0, in_ready_c},  {31'd0, mq.size() < 2});
        check_eq("in_ready_h",  {31'd0, in_ready_h},  {31'd0, mq.size() < 2});
        check_eq("out_data_c",  out_data_c, last_c);
        check_eq("out_data_h",  out_data_h, last_h);
    endtask

    initial begin
        last_c = '0;
        last_h = '0;

        // Reset, then a single beat
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 1, 32'h0000_1234);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        // Back-to-back streaming
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 32'h10 + i);
        step(0, 0, 0, 1, 32'h0);

        // Backpressure fills skid, then drain in order
        step(0, 0, 1, 0, 32'hA);
        step(0, 0, 1, 0, 32'hB);
        step(0, 0, 1, 0, 32'hEE);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        // Flush collides with an incoming beat while full
        step(0, 0, 1, 0, 32'hA);
        step(0, 0, 1, 0, 32'hB);
        step(0, 1, 1, 0, 32'hC);
        step(0, 0, 0, 1, 32'h0);

        // Flush while busy: hold variant keeps 0x55 on out_data
        step(0, 0, 1, 0, 32'h55);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Reset beats flush and handshakes, then a normal beat
        step(0, 0, 1, 0, 32'hA);
        step(0, 0, 1, 0, 32'hB);
        step(1, 0, 1, 0, 32'hC);
        step(0, 0, 1, 1, 32'h99);
        step(0, 0, 0, 1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
